// File: rtl/adma_pkg.sv
// Shared types for the AXI DMA destination datamover: descriptor layout and stream constants.
// Widths here are the defaults that the datamover parameters are expected to keep.
package adma_pkg;

    localparam int ADMA_MST_ID_W      = 5;
    localparam int ADMA_LEN_W         = 8;
    localparam int ADMA_DST_DATA_W    = 256;
    localparam int ADMA_DST_BYTE_AMT  = ADMA_DST_DATA_W / 8;

    typedef struct packed {
        logic [ADMA_MST_ID_W-1:0] id;
        logic [ADMA_LEN_W-1:0]    len;
    } atx_desc_t;

    function automatic logic [ADMA_DST_BYTE_AMT-1:0] adma_keep_all();
        return '1;
    endfunction

endpackage

// File: rtl/adma_dm_dst_axis_if.sv
// AXI-Stream bundle carried out of the destination datamover.
// Master drives t* payload and tvalid; slave returns tready.
interface adma_dm_dst_axis_if #(
    parameter int ID_W     = 5,
    parameter int DATA_W   = 256,
    parameter int BYTE_AMT = DATA_W / 8
);
    logic [ID_W-1:0]     m_tid_o;
    logic                m_tdest_o;
    logic [DATA_W-1:0]   m_tdata_o;
    logic [BYTE_AMT-1:0] m_tkeep_o;
    logic [BYTE_AMT-1:0] m_tstrb_o;
    logic                m_tlast_o;
    logic                m_tvalid_o;
    logic                m_tready_i;

    modport master (
        output m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
        input  m_tready_i
    );

    modport slave (
        input  m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
        output m_tready_i
    );
endinterface

// File: rtl/adma_dst_ord_fifo.sv
// In-order descriptor queue: registered pointers with wrap bit, head read combinationally.
// Zero-latency head; full blocks pushes, empty blocks pops (caller guards both).
module adma_dst_ord_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
    end

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/skid_buffer.sv
// Fully registered 2-entry skid buffer: one cycle latency, full throughput.
// in_rdy_o comes from a flop; a stalled output parks one extra beat in the skid slot.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);
    logic         out_vld_q, skid_vld_q;
    logic [W-1:0] out_dat_q, skid_dat_q;

    assign in_rdy_o  = !skid_vld_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_dat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else if (out_rdy_i || !out_vld_q) begin
            if (skid_vld_q) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= skid_dat_q;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= in_vld_i;
                if (in_vld_i) out_dat_q <= in_dat_i;
            end
        end else if (in_vld_i && !skid_vld_q) begin
            skid_vld_q <= 1'b1;
            skid_dat_q <= in_dat_i;
        end
    end

endmodule

// File: rtl/adma_dm_dst_axis.sv
// Destination AXI-Stream datamover: tags write beats with queued descriptor IDs and TLAST.
// One cycle beat latency; stream backpressure reaches atx_wdata_rdy within two cycles.
module adma_dm_dst_axis
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM      = 4,
    parameter int ATX_DST_DATA_W   = 256,
    parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
    parameter int MST_ID_W         = 5,
    parameter int ATX_LEN_W        = 8,
    parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [MST_ID_W-1:0]       atx_awid,
    input  logic [ATX_LEN_W-1:0]      atx_awlen,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    input  logic [ATX_DST_DATA_W-1:0] atx_wdata,
    input  logic                      atx_wdata_vld,
    output logic                      atx_wdata_rdy,
    output logic                      atx_done_vld,
    output logic [MST_ID_W-1:0]       atx_done_id,
    adma_dm_dst_axis_if.master        m_axis
);
    localparam int PLD_W = MST_ID_W + 1 + ATX_DST_DATA_W;

    atx_desc_t              desc_in, head;
    logic                   q_full, q_empty, q_push, q_pop;
    logic                   beat_acc, beat_last, skid_in_rdy;
    logic [ATX_LEN_W-1:0]   cnt_q, cnt_d;
    logic [PLD_W-1:0]       skid_in, skid_out;

    assign desc_in = '{id: atx_awid, len: atx_awlen};
    assign atx_rdy = !q_full;
    assign q_push  = atx_vld && !q_full;

    assign atx_wdata_rdy = !q_empty && skid_in_rdy;
    assign beat_acc      = atx_wdata_vld && atx_wdata_rdy;
    // Compare before increment, so len of all ones runs the full counter range.
    assign beat_last     = (cnt_q == head.len);
    assign q_pop         = beat_acc && beat_last;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_acc) cnt_d = beat_last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    adma_dst_ord_fifo #(
        .W     ($bits(atx_desc_t)),
        .DEPTH (ATX_NUM_OSTD)
    ) u_ord_fifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (q_push),
        .dat_i   (desc_in),
        .full_o  (q_full),
        .pop_i   (q_pop),
        .head_o  (head),
        .empty_o (q_empty)
    );

    assign skid_in = {head.id, beat_last, atx_wdata};

    skid_buffer #(
        .W (PLD_W)
    ) u_out_skid (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .in_vld_i  (beat_acc),
        .in_rdy_o  (skid_in_rdy),
        .in_dat_i  (skid_in),
        .out_vld_o (m_axis.m_tvalid_o),
        .out_rdy_i (m_axis.m_tready_i),
        .out_dat_o (skid_out)
    );

    assign {m_axis.m_tid_o, m_axis.m_tlast_o, m_axis.m_tdata_o} = skid_out;
    assign m_axis.m_tdest_o = 1'b0;
    assign m_axis.m_tkeep_o = ATX_DST_BYTE_AMT'(adma_keep_all());
    assign m_axis.m_tstrb_o = ATX_DST_BYTE_AMT'(adma_keep_all());

    assign atx_done_vld = m_axis.m_tvalid_o && m_axis.m_tready_i && m_axis.m_tlast_o;
    assign atx_done_id  = m_axis.m_tid_o;

endmodule

// File: tb/tb_adma_dm_dst_axis.sv
// Directed bench for adma_dm_dst_axis: inputs change #1 after posedge, outputs sampled on negedge.
module tb_adma_dm_dst_axis;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [4:0]   atx_awid;
    logic [7:0]   atx_awlen;
    logic         atx_vld, atx_rdy;
    logic [255:0] atx_wdata;
    logic         atx_wdata_vld, atx_wdata_rdy;
    logic         atx_done_vld;
    logic [4:0]   atx_done_id;

    always #5 clk = ~clk;

    adma_dm_dst_axis_if #(.ID_W(5), .DATA_W(256), .BYTE_AMT(32)) m_axis ();

    adma_dm_dst_axis dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .atx_awid      (atx_awid),
        .atx_awlen     (atx_awlen),
        .atx_vld       (atx_vld),
        .atx_rdy       (atx_rdy),
        .atx_wdata     (atx_wdata),
        .atx_wdata_vld (atx_wdata_vld),
        .atx_wdata_rdy (atx_wdata_rdy),
        .atx_done_vld  (atx_done_vld),
        .atx_done_id   (atx_done_id),
        .m_axis        (m_axis)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc = 0;

    logic [255:0] rx_dat [$];
    logic [4:0]   rx_id  [$];
    logic         rx_last[$];
    logic         rx_done[$];
    logic [4:0]   rx_did [$];
    int           rx_cyc [$];

    logic         prev_stall = 1'b0;
    logic [255:0] prev_dat;
    logic [4:0]   prev_id;
    logic         prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: logs every handshake and checks payload holds while stalled.
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            if (prev_stall) begin
                check("stall_tvalid", m_axis.m_tvalid_o, 1'b1);
                check("stall_tdata",  m_axis.m_tdata_o, prev_dat);
                check("stall_tid",    m_axis.m_tid_o, prev_id);
                check("stall_tlast",  m_axis.m_tlast_o, prev_last);
            end
            if (m_axis.m_tvalid_o && m_axis.m_tready_i) begin
                rx_dat.push_back(m_axis.m_tdata_o);
                rx_id.push_back(m_axis.m_tid_o);
                rx_last.push_back(m_axis.m_tlast_o);
                rx_done.push_back(atx_done_vld);
                rx_did.push_back(atx_done_id);
                rx_cyc.push_back(cyc);
            end
            prev_stall = m_axis.m_tvalid_o && !m_axis.m_tready_i;
            prev_dat   = m_axis.m_tdata_o;
            prev_id    = m_axis.m_tid_o;
            prev_last  = m_axis.m_tlast_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_rx();
        rx_dat.delete(); rx_id.delete(); rx_last.delete();
        rx_done.delete(); rx_did.delete(); rx_cyc.delete();
    endtask

    // Entered and left at posedge+1.
    task automatic push_desc(input logic [4:0] id, input logic [7:0] len);
        int k = 0;
        atx_awid  = id;
        atx_awlen = len;
        atx_vld   = 1'b1;
        @(negedge clk);
        while (!atx_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("desc_rdy", atx_rdy, 1'b1);
        @(posedge clk); #1;
        atx_vld = 1'b0;
    endtask

    task automatic run(input int n, input logic [255:0] base, input bit rnd, input int exp_rx);
        int sent = 0;
        int k = 0;
        while ((sent < n || rx_dat.size() < exp_rx) && k < 3000) begin
            m_axis.m_tready_i = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            atx_wdata_vld = (sent < n);
            atx_wdata     = base + 256'(sent);
            @(negedge clk);
            if (atx_wdata_vld && atx_wdata_rdy) begin
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            k++;
        end
        atx_wdata_vld     = 1'b0;
        m_axis.m_tready_i = 1'b1;
        check("run_rx_count", rx_dat.size(), exp_rx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlast;
        int derr;
        logic [4:0] exp_id   [3];
        logic       exp_last [3];

        aresetn = 1'b0; atx_vld = 1'b0; atx_awid = '0; atx_awlen = '0;
        atx_wdata = '0; atx_wdata_vld = 1'b0; m_axis.m_tready_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_tvalid", m_axis.m_tvalid_o, 1'b0);
        check("rst_tlast",  m_axis.m_tlast_o, 1'b0);
        check("rst_tid",    m_axis.m_tid_o, 5'd0);
        check("rst_tdata",  m_axis.m_tdata_o, 256'd0);
        check("rst_done",   atx_done_vld, 1'b0);
        check("rst_done_id", atx_done_id, 5'd0);
        check("rst_wrdy",   atx_wdata_rdy, 1'b0);
        check("rst_atx_rdy", atx_rdy, 1'b1);
        check("tkeep_ones", m_axis.m_tkeep_o, {32{1'b1}});
        check("tstrb_ones", m_axis.m_tstrb_o, {32{1'b1}});
        check("tdest_zero", m_axis.m_tdest_o, 1'b0);
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Single burst id=3 len=3; beat offered alongside the descriptor must stall.
        clear_rx();
        atx_awid = 5'd3; atx_awlen = 8'd3; atx_vld = 1'b1;
        atx_wdata = 256'hA0; atx_wdata_vld = 1'b1;
        @(negedge clk);
        check("t1_atx_rdy", atx_rdy, 1'b1);
        check("t1_wrdy_same_cycle", atx_wdata_rdy, 1'b0);
        @(posedge clk); #1;
        atx_vld = 1'b0;
        run(4, 256'hA0, 1'b0, 4);
        for (int i = 0; i < 4 && i < rx_dat.size(); i++) begin
            check("t1_tdata", rx_dat[i], 256'hA0 + 256'(i));
            check("t1_tid",   rx_id[i], 5'd3);
            check("t1_tlast", rx_last[i], (i == 3));
            check("t1_done",  rx_done[i], (i == 3));
        end
        if (rx_dat.size() == 4) begin
            check("t1_done_id", rx_did[3], 5'd3);
            check("t1_latency", rx_cyc[0], first_acc + 1);
        end

        // Back-to-back descriptors id=1 len=0, id=2 len=1.
        clear_rx();
        push_desc(5'd1, 8'd0);
        push_desc(5'd2, 8'd1);
        run(3, 256'hB0, 1'b0, 3);
        exp_id   = '{5'd1, 5'd2, 5'd2};
        exp_last = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3 && i < rx_dat.size(); i++) begin
            check("t2_tid",   rx_id[i], exp_id[i]);
            check("t2_tlast", rx_last[i], exp_last[i]);
            check("t2_tdata", rx_dat[i], 256'hB0 + 256'(i));
            if (i > 0) check("t2_no_bubble", rx_cyc[i], rx_cyc[i-1] + 1);
        end
        if (rx_dat.size() == 3) begin
            check("t2_done_id0", rx_did[0], 5'd1);
            check("t2_done_id2", rx_did[2], 5'd2);
        end

        // Queue full: four descriptors, no data.
        clear_rx();
        for (int i = 0; i < 4; i++) push_desc(5'(4 + i), 8'd0);
        @(negedge clk);
        check("t3_full_rdy", atx_rdy, 1'b0);
        @(posedge clk); #1;
        atx_wdata = 256'hC0; atx_wdata_vld = 1'b1;
        @(negedge clk);
        check("t3_wrdy", atx_wdata_rdy, 1'b1);
        check("t3_rdy_at_pop", atx_rdy, 1'b0);
        @(posedge clk); #1;
        atx_wdata_vld = 1'b0;
        @(negedge clk);
        check("t3_rdy_reassert", atx_rdy, 1'b1);
        @(posedge clk); #1;
        run(3, 256'hC1, 1'b0, 4);
        for (int i = 0; i < 4 && i < rx_dat.size(); i++) begin
            check("t3_tid",   rx_id[i], 5'(4 + i));
            check("t3_tlast", rx_last[i], 1'b1);
            check("t3_tdata", rx_dat[i], 256'hC0 + 256'(i));
        end

        // Random backpressure over a 16-beat burst.
        clear_rx();
        push_desc(5'd9, 8'd15);
        run(16, 256'h100, 1'b1, 16);
        nlast = 0;
        for (int i = 0; i < rx_dat.size(); i++) begin
            check("t4_tdata", rx_dat[i], 256'h100 + 256'(i));
            check("t4_tid",   rx_id[i], 5'd9);
            if (rx_last[i]) nlast++;
        end
        check("t4_one_tlast", nlast, 1);
        if (rx_dat.size() == 16) check("t4_tlast_pos", rx_last[15], 1'b1);

        // Beats with no descriptor stall, then a 256-beat max-length burst.
        clear_rx();
        atx_wdata = '0; atx_wdata_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_nodesc_wrdy", atx_wdata_rdy, 1'b0);
            @(posedge clk); #1;
        end
        check("t5_nodesc_rx", rx_dat.size(), 0);
        push_desc(5'd17, 8'd255);
        run(256, 256'd0, 1'b0, 256);
        nlast = 0;
        derr  = 0;
        for (int i = 0; i < rx_dat.size(); i++) begin
            if (rx_last[i]) nlast++;
            if (rx_dat[i] !== 256'(i) || rx_id[i] !== 5'd17) derr++;
        end
        check("t5_one_tlast", nlast, 1);
        check("t5_data_errs", derr, 0);
        if (rx_dat.size() == 256) begin
            check("t5_tlast_256", rx_last[255], 1'b1);
            check("t5_done_id", rx_did[255], 5'd17);
        end

        // Reset after beat 2 of a len=7 burst.
        clear_rx();
        push_desc(5'd6, 8'd7);
        run(2, 256'h300, 1'b0, 2);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("t6_tvalid", m_axis.m_tvalid_o, 1'b0);
        check("t6_wrdy_empty", atx_wdata_rdy, 1'b0);
        check("t6_atx_rdy", atx_rdy, 1'b1);
        @(posedge clk); #1;
        clear_rx();
        push_desc(5'd8, 8'd1);
        run(2, 256'h400, 1'b0, 2);
        if (rx_dat.size() == 2) begin
            check("t6_tid0",   rx_id[0], 5'd8);
            check("t6_tid1",   rx_id[1], 5'd8);
            check("t6_tlast0", rx_last[0], 1'b0);
            check("t6_tlast1", rx_last[1], 1'b1);
            check("t6_done1",  rx_done[1], 1'b1);
            check("t6_tdata1", rx_dat[1], 256'h401);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
